// File: rtl/pipeline_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl_pkg
// Shared types for the pipeline stall/flush sequencer:
//   state_e  - sequencer states
//   pc_sel_e - PC source select encoding driven to the fetch stage
//   ctrl_t   - bundle of all per-cycle control outputs
//   cnt_width() - counter width for a given cycle-count parameter
// ---------------------------------------------------------------------------
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_MEM_WAIT  = 2'd1,
        ST_INT_DRAIN = 2'd2,
        ST_INT_ENTER = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        PC_SEQ    = 2'd0,
        PC_BRANCH = 2'd1,
        PC_VECTOR = 2'd2,
        PC_EPC    = 2'd3
    } pc_sel_e;

    typedef struct packed {
        logic    stall_if;
        logic    stall_id;
        logic    stall_ex;
        logic    stall_mem;
        logic    flush_if_id;
        logic    flush_id_ex;
        logic    flush_ex_mem;
        pc_sel_e pc_sel;
        logic    int_ack;
        logic    mem_timeout;
    } ctrl_t;

    // Width needed to hold n-1; a count of 1 still needs one bit of storage.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl_if
// Bundle between hazard sources / pipeline registers and the sequencer.
//   Hazard inputs : load_use_hazard, mem_req_ex_mem, mem_ack, branch_taken,
//                   rti_ex, int_req
//   Controls out  : stall_if/id/ex/mem, flush_if_id/id_ex/ex_mem, pc_sel[1:0],
//                   int_ack, int_active, mem_timeout
// master = sequencer view, slave = pipeline view.
// ---------------------------------------------------------------------------
interface pipeline_ctrl_if;

    logic       load_use_hazard;
    logic       mem_req_ex_mem;
    logic       mem_ack;
    logic       branch_taken;
    logic       rti_ex;
    logic       int_req;

    logic       stall_if;
    logic       stall_id;
    logic       stall_ex;
    logic       stall_mem;
    logic       flush_if_id;
    logic       flush_id_ex;
    logic       flush_ex_mem;
    logic [1:0] pc_sel;
    logic       int_ack;
    logic       int_active;
    logic       mem_timeout;

    modport master (
        input  load_use_hazard, mem_req_ex_mem, mem_ack, branch_taken, rti_ex, int_req,
        output stall_if, stall_id, stall_ex, stall_mem,
        output flush_if_id, flush_id_ex, flush_ex_mem,
        output pc_sel, int_ack, int_active, mem_timeout
    );

    modport slave (
        output load_use_hazard, mem_req_ex_mem, mem_ack, branch_taken, rti_ex, int_req,
        input  stall_if, stall_id, stall_ex, stall_mem,
        input  flush_if_id, flush_id_ex, flush_ex_mem,
        input  pc_sel, int_ack, int_active, mem_timeout
    );

endinterface

// File: rtl/pipe_down_counter.sv
// ---------------------------------------------------------------------------
// pipe_down_counter
// Loadable down counter that saturates at zero.
//   clk, rst  : clock, asynchronous active-high reset (count -> 0)
//   load      : load load_val (has priority over en)
//   load_val  : value to load
//   en        : decrement by one when non-zero
//   zero      : count is currently zero
// ---------------------------------------------------------------------------
module pipe_down_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic             zero
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned and infers a latch.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (en && (count_q != '0)) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl
// Central stall/flush sequencer for the 5-stage core. One prioritised state
// machine turns hazard/handshake/branch/interrupt inputs into per-stage
// hold and bubble controls plus the PC source select.
//   clk, rst : core clock, asynchronous active-high reset
//   bus      : pipeline_ctrl_if.master (hazard inputs, control outputs)
// Parameters:
//   INT_DRAIN   : cycles older instructions drain before interrupt entry (>=1)
//   MEM_TIMEOUT : MEM_WAIT cycles before the access is aborted (>=2)
// Outputs are Mealy (state + current inputs); state, counters and
// int_active are registered.
// ---------------------------------------------------------------------------
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int INT_DRAIN   = 2,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    pipeline_ctrl_if.master       bus
);

    localparam int DRAIN_W = cnt_width(INT_DRAIN);
    localparam int TMR_W   = cnt_width(MEM_TIMEOUT);
    localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(INT_DRAIN - 1);
    localparam logic [TMR_W-1:0]   TMR_LOAD   = TMR_W'(MEM_TIMEOUT - 1);

    state_e state_q, state_d;
    logic   int_active_q, int_active_d;
    ctrl_t  ctrl;

    logic drain_load, drain_en, drain_zero;
    logic tmr_load, tmr_en, tmr_zero;
    logic mem_stall;

    // A memory access is outstanding when a load/store sits in EX/MEM and
    // the data memory has not completed it this cycle.
    assign mem_stall = bus.mem_req_ex_mem & ~bus.mem_ack;

    always_comb begin
        ctrl         = '0;
        state_d      = state_q;
        int_active_d = int_active_q;
        drain_load   = 1'b0;
        drain_en     = 1'b0;
        tmr_load     = 1'b0;
        tmr_en       = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (mem_stall) begin
                    {ctrl.stall_if, ctrl.stall_id, ctrl.stall_ex, ctrl.stall_mem} = 4'b1111;
                    tmr_load = 1'b1;
                    state_d  = ST_MEM_WAIT;
                end else if (bus.rti_ex) begin
                    // RTI outranks a pending interrupt; the request is seen
                    // again next cycle once int_active has dropped.
                    ctrl.flush_if_id = 1'b1;
                    ctrl.flush_id_ex = 1'b1;
                    ctrl.pc_sel      = PC_EPC;
                    int_active_d     = 1'b0;
                end else if (bus.int_req && !int_active_q) begin
                    ctrl.stall_if    = 1'b1;
                    ctrl.flush_if_id = 1'b1;
                    drain_load       = 1'b1;
                    state_d          = ST_INT_DRAIN;
                end else if (bus.branch_taken) begin
                    ctrl.flush_if_id = 1'b1;
                    ctrl.flush_id_ex = 1'b1;
                    ctrl.pc_sel      = PC_BRANCH;
                end else if (bus.load_use_hazard) begin
                    ctrl.stall_if    = 1'b1;
                    ctrl.stall_id    = 1'b1;
                    ctrl.flush_id_ex = 1'b1;
                end
            end

            ST_MEM_WAIT: begin
                if (bus.mem_ack) begin
                    state_d = ST_RUN;
                end else if (tmr_zero) begin
                    // Abort: squash the stuck access and let the pipe move.
                    ctrl.mem_timeout  = 1'b1;
                    ctrl.flush_ex_mem = 1'b1;
                    state_d           = ST_RUN;
                end else begin
                    {ctrl.stall_if, ctrl.stall_id, ctrl.stall_ex, ctrl.stall_mem} = 4'b1111;
                    tmr_en = 1'b1;
                end
            end

            ST_INT_DRAIN: begin
                ctrl.stall_if    = 1'b1;
                ctrl.flush_if_id = 1'b1;
                if (mem_stall) begin
                    // Draining pauses while memory holds the pipe.
                    {ctrl.stall_if, ctrl.stall_id, ctrl.stall_ex, ctrl.stall_mem} = 4'b1111;
                end else begin
                    // A branch still squashes its shadow, but the PC is not
                    // redirected: the interrupt vector overrides it.
                    ctrl.flush_id_ex = bus.branch_taken;
                    if (drain_zero) begin
                        state_d = ST_INT_ENTER;
                    end else begin
                        drain_en = 1'b1;
                    end
                end
            end

            ST_INT_ENTER: begin
                ctrl.pc_sel      = PC_VECTOR;
                ctrl.int_ack     = 1'b1;
                ctrl.flush_if_id = 1'b1;
                ctrl.flush_id_ex = 1'b1;
                int_active_d     = 1'b1;
                state_d          = ST_RUN;
            end

            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_RUN;
            int_active_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            int_active_q <= int_active_d;
        end
    end

    pipe_down_counter #(.WIDTH(DRAIN_W)) u_drain_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (drain_load),
        .load_val (DRAIN_LOAD),
        .en       (drain_en),
        .zero     (drain_zero)
    );

    pipe_down_counter #(.WIDTH(TMR_W)) u_mem_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (TMR_LOAD),
        .en       (tmr_en),
        .zero     (tmr_zero)
    );

    assign bus.stall_if     = ctrl.stall_if;
    assign bus.stall_id     = ctrl.stall_id;
    assign bus.stall_ex     = ctrl.stall_ex;
    assign bus.stall_mem    = ctrl.stall_mem;
    assign bus.flush_if_id  = ctrl.flush_if_id;
    assign bus.flush_id_ex  = ctrl.flush_id_ex;
    assign bus.flush_ex_mem = ctrl.flush_ex_mem;
    assign bus.pc_sel       = ctrl.pc_sel;
    assign bus.int_ack      = ctrl.int_ack;
    assign bus.mem_timeout  = ctrl.mem_timeout;
    assign bus.int_active   = int_active_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_ctrl
// Directed scenarios followed by random traffic, every cycle compared with a
// cycle-count reference model of the sequencer rules. Output vector layout:
// {stall_if,stall_id,stall_ex,stall_mem, flush_if_id,flush_id_ex,flush_ex_mem,
//  pc_sel[1:0], int_ack, int_active, mem_timeout}
// ---------------------------------------------------------------------------
module tb_pipeline_ctrl;

    localparam int INT_DRAIN   = 2;
    localparam int MEM_TIMEOUT = 4;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;
    logic [11:0] last_obs;

    pipeline_ctrl_if bus ();

    pipeline_ctrl #(
        .INT_DRAIN   (INT_DRAIN),
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Tracks progress as plain counts: memory cycles already waited, drain
    // cycles still owed, and whether vector entry is due this cycle.
    bit m_in_wait, m_enter, m_active;
    int m_waited, m_drain_left;
    bit nx_in_wait, nx_enter, nx_active;
    int nx_waited, nx_drain_left;

    task automatic model_reset();
        m_in_wait = 0; m_enter = 0; m_active = 0; m_waited = 0; m_drain_left = 0;
    endtask

    task automatic model_commit();
        m_in_wait = nx_in_wait; m_enter = nx_enter; m_active = nx_active;
        m_waited = nx_waited; m_drain_left = nx_drain_left;
    endtask

    task automatic model_eval(input bit lu, mreq, mack, br, rti, irq, output logic [11:0] e);
        bit [3:0] s   = 4'b0000;
        bit [2:0] f   = 3'b000;
        int       pc  = 0;
        bit       ack = 0;
        bit       tmo = 0;
        nx_in_wait = m_in_wait; nx_enter = m_enter; nx_active = m_active;
        nx_waited = m_waited; nx_drain_left = m_drain_left;
        if (m_in_wait) begin
            if (mack) nx_in_wait = 0;
            else if (m_waited + 1 == MEM_TIMEOUT) begin tmo = 1; f = 3'b001; nx_in_wait = 0; end
            else begin s = 4'b1111; nx_waited = m_waited + 1; end
        end else if (m_enter) begin
            pc = 2; ack = 1; f = 3'b110; nx_active = 1; nx_enter = 0;
        end else if (m_drain_left > 0) begin
            s = 4'b1000; f = 3'b100;
            if (mreq && !mack) s = 4'b1111;
            else begin
                if (br) f[1] = 1'b1;
                nx_drain_left = m_drain_left - 1;
                if (nx_drain_left == 0) nx_enter = 1;
            end
        end else begin
            if (mreq && !mack) begin s = 4'b1111; nx_in_wait = 1; nx_waited = 0; end
            else if (rti) begin f = 3'b110; pc = 3; nx_active = 0; end
            else if (irq && !m_active) begin s = 4'b1000; f = 3'b100; nx_drain_left = INT_DRAIN; end
            else if (br) begin f = 3'b110; pc = 1; end
            else if (lu) begin s = 4'b1100; f = 3'b010; end
        end
        e = {s, f, 2'(pc), ack, m_active, tmo};
    endtask

    // ---------------- helpers ----------------
    function automatic logic [11:0] mk(logic [3:0] s, logic [2:0] f, logic [1:0] pc,
                                       logic ack, logic act, logic tmo);
        return {s, f, pc, ack, act, tmo};
    endfunction

    function automatic logic [11:0] get_obs();
        return {bus.stall_if, bus.stall_id, bus.stall_ex, bus.stall_mem,
                bus.flush_if_id, bus.flush_id_ex, bus.flush_ex_mem,
                bus.pc_sel, bus.int_ack, bus.int_active, bus.mem_timeout};
    endfunction

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit lu, mreq, mack, br, rti, irq);
        bus.load_use_hazard = lu;
        bus.mem_req_ex_mem  = mreq;
        bus.mem_ack         = mack;
        bus.branch_taken    = br;
        bus.rti_ex          = rti;
        bus.int_req         = irq;
    endtask

    // One clock cycle: drive after the falling edge, compare with the model
    // mid-cycle, advance the model on the rising edge.
    task automatic step(input string tag, input bit lu, mreq, mack, br, rti, irq);
        logic [11:0] e;
        @(negedge clk);
        drive(lu, mreq, mack, br, rti, irq);
        #1;
        model_eval(lu, mreq, mack, br, rti, irq, e);
        last_obs = get_obs();
        chk(tag, last_obs, e);
        @(posedge clk);
        model_commit();
    endtask

    initial begin
        int ack_pct;
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        model_reset();
        #2;
        chk("reset_state", get_obs(), 12'h000);
        @(negedge clk);
        rst = 1'b0;

        step("idle", 0, 0, 0, 0, 0, 0);
        chk("idle_zero", last_obs, 12'h000);

        // Load-use: one bubble, for that cycle only.
        step("lu", 1, 0, 0, 0, 0, 0);
        chk("load_use", last_obs, mk(4'b1100, 3'b010, 2'd0, 0, 0, 0));
        step("lu_after", 0, 0, 0, 0, 0, 0);
        chk("load_use_once", last_obs, 12'h000);

        // Memory wait: three un-acked cycles, then ack.
        for (int i = 0; i < 3; i++) begin
            step("mw", 0, 1, 0, 0, 0, 0);
            chk("mem_wait_stall", last_obs, mk(4'b1111, 3'b000, 2'd0, 0, 0, 0));
        end
        step("mw_ack", 0, 1, 1, 0, 0, 0);
        chk("mem_ack_release", last_obs, 12'h000);
        step("mw_run", 0, 0, 0, 0, 0, 0);
        chk("mem_back_to_run", last_obs, 12'h000);

        // Same-cycle ack: no stall at all.
        step("mw0", 0, 1, 1, 0, 0, 0);
        chk("mem_same_cycle_ack", last_obs, 12'h000);

        // Timeout: RUN stall cycle, then 3 wait cycles, abort in the 4th.
        step("to_run", 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < MEM_TIMEOUT - 1; i++) begin
            step("to_wait", 0, 1, 0, 0, 0, 0);
            chk("timeout_wait", last_obs, mk(4'b1111, 3'b000, 2'd0, 0, 0, 0));
        end
        step("to_fire", 0, 1, 0, 0, 0, 0);
        chk("timeout_pulse", last_obs, mk(4'b0000, 3'b001, 2'd0, 0, 0, 1));
        step("to_after", 0, 0, 0, 0, 0, 0);
        chk("timeout_to_run", last_obs, 12'h000);

        // Interrupt entry after INT_DRAIN drain cycles.
        step("irq", 0, 0, 0, 0, 0, 1);
        chk("irq_accept", last_obs, mk(4'b1000, 3'b100, 2'd0, 0, 0, 0));
        for (int i = 0; i < INT_DRAIN; i++) begin
            step("drain", 0, 0, 0, 0, 0, 0);
            chk("irq_drain", last_obs, mk(4'b1000, 3'b100, 2'd0, 0, 0, 0));
        end
        step("enter", 0, 0, 0, 0, 0, 0);
        chk("irq_enter", last_obs, mk(4'b0000, 3'b110, 2'd2, 1, 0, 0));
        step("active", 0, 0, 0, 0, 0, 0);
        chk("int_active_set", last_obs, mk(4'b0000, 3'b000, 2'd0, 0, 1, 0));
        step("irq_nested", 0, 0, 0, 0, 0, 1);
        chk("irq_ignored_active", last_obs, mk(4'b0000, 3'b000, 2'd0, 0, 1, 0));
        step("rti", 0, 0, 0, 0, 1, 0);
        chk("rti_epc", last_obs, mk(4'b0000, 3'b110, 2'd3, 0, 1, 0));
        step("rti_after", 0, 0, 0, 0, 0, 0);
        chk("int_active_clear", last_obs, 12'h000);

        // Priorities.
        step("br_lu", 1, 0, 0, 1, 0, 0);
        chk("branch_over_lu", last_obs, mk(4'b0000, 3'b110, 2'd1, 0, 0, 0));
        step("rti_irq", 0, 0, 0, 0, 1, 1);
        chk("rti_over_irq", last_obs, mk(4'b0000, 3'b110, 2'd3, 0, 0, 0));
        step("irq_next", 0, 0, 0, 0, 0, 1);
        chk("irq_after_rti", last_obs, mk(4'b1000, 3'b100, 2'd0, 0, 0, 0));
        // Drain with a memory stall (frozen) and a branch (no redirect).
        step("drain_mem", 0, 1, 0, 0, 0, 0);
        chk("drain_mem_stall", last_obs, mk(4'b1111, 3'b100, 2'd0, 0, 0, 0));
        step("drain_br", 0, 0, 0, 1, 0, 0);
        chk("drain_branch", last_obs, mk(4'b1000, 3'b110, 2'd0, 0, 0, 0));
        step("drain_last", 0, 0, 0, 0, 0, 0);
        chk("drain_extended", last_obs, mk(4'b1000, 3'b100, 2'd0, 0, 0, 0));
        step("enter2", 0, 0, 0, 0, 0, 0);
        chk("irq_enter2", last_obs, mk(4'b0000, 3'b110, 2'd2, 1, 0, 0));
        step("rti2", 0, 0, 0, 0, 1, 0);
        step("idle2", 0, 0, 0, 0, 0, 0);

        // Async reset in the middle of a drain.
        step("irq3", 0, 0, 0, 0, 0, 1);
        step("drain3", 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        #1;
        chk("drain_before_reset", get_obs(), mk(4'b1000, 3'b100, 2'd0, 0, 0, 0));
        #1;
        rst = 1'b1;
        #1;
        chk("async_reset_mid_drain", get_obs(), 12'h000);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < INT_DRAIN + 2; i++) begin
            step("post_reset", 0, 0, 0, 0, 0, 0);
            chk("no_ack_after_reset", last_obs, 12'h000);
        end

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            ack_pct = ((i / 200) % 2 == 0) ? 50 : 12;
            step($sformatf("rand%0d", i),
                 $urandom_range(0, 99) < 20,
                 $urandom_range(0, 99) < 30,
                 $urandom_range(0, 99) < ack_pct,
                 $urandom_range(0, 99) < 20,
                 $urandom_range(0, 99) < 8,
                 $urandom_range(0, 99) < 15);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central stall/flush sequencer for the 5-stage core. Consumes the load-use hazard flag, the data-memory handshake, branch resolution, interrupt requests and RTI, and drives per-stage hold/bubble controls plus the PC source select. Replaces ad-hoc stall logic scattered across stages with one prioritised state machine between the hazard unit and the pipeline registers.

## Interface
Parameters:
- INT_DRAIN, 2, cycles older instructions drain before interrupt entry (≥1)
- MEM_TIMEOUT, 64, max cycles in MEM_WAIT before abort (≥2)

Ports:
- clk  in  1  core clock
- rst  in  1  reset, asynchronous, active-high
- load_use_hazard  in  1  load-use hazard from hazard unit
- mem_req_ex_mem  in  1  load/store in EX/MEM
- mem_ack  in  1  data memory completes access this cycle
- branch_taken  in  1  taken branch/jump resolved in EX
- rti_ex  in  1  RTI in EX
- int_req  in  1  level interrupt request
- stall_if, stall_id, stall_ex, stall_mem  out  1 each  hold stage register
- flush_if_id, flush_id_ex, flush_ex_mem  out  1 each  load bubble into register
- pc_sel  out  2  0 seq, 1 branch target, 2 interrupt vector, 3 saved EPC
- int_ack  out  1  one-cycle interrupt accept pulse
- int_active  out  1  handler running, nesting blocked
- mem_timeout  out  1  one-cycle pulse on memory abort

## Operation
- States: RUN, MEM_WAIT, INT_DRAIN, INT_ENTER. Outputs Mealy (state + inputs); state, counter, int_active registered.
- RUN, priority high→low:
  - mem_req_ex_mem & !mem_ack: all four stalls high, → MEM_WAIT, timer loads MEM_TIMEOUT-1.
  - rti_ex: flush_if_id, flush_id_ex, pc_sel=3; int_active cleared at edge.
  - int_req & !int_active: stall_if, flush_if_id; → INT_DRAIN, counter loads INT_DRAIN-1.
  - branch_taken: flush_if_id, flush_id_ex, pc_sel=1.
  - load_use_hazard: stall_if, stall_id, flush_id_ex.
  - else all controls 0, pc_sel=0.
- MEM_WAIT: all stalls high while mem_ack=0; mem_ack=1: stalls low same cycle, → RUN. Timer reaches 0 without ack: mem_timeout pulse, flush_ex_mem, stalls low, → RUN.
- INT_DRAIN: stall_if & flush_if_id held; counter decrements per cycle; at 0 → INT_ENTER. mem stall inside drain: all stalls high, counter frozen. branch_taken inside drain: flush_id_ex only, no redirect (vector overrides).
- INT_ENTER (1 cycle): pc_sel=2, int_ack=1, flush_if_id, flush_id_ex; int_active set at edge; → RUN.
- int_req ignored while int_active=1. int_req deasserting during INT_DRAIN does not cancel entry.

## Timing
- Reset (async, any state): state RUN, counters 0, int_active 0; with inputs low every output 0, pc_sel 0.
- Zero-latency combinational response to inputs in RUN; no registered output delay.
- mem_req with mem_ack same cycle: no stall cycle.
- Load-use: exactly one bubble per assertion cycle.
- Interrupt latency int_req→int_ack: INT_DRAIN+1 cycles with no memory stalls, extended one per MEM_WAIT cycle.
- Timeout: mem_timeout fires in the MEM_TIMEOUT-th MEM_WAIT cycle.
- rti_ex and int_req same cycle: RTI wins; interrupt can be taken next cycle.
- Reset mid-MEM_WAIT or mid-drain: abandon, no int_ack, no mem_timeout.

## Structure
- Package pipeline_ctrl_pkg: state enum, pc_sel enum (PC_SEQ, PC_BRANCH, PC_VECTOR, PC_EPC).
- Sub-module pipe_down_counter (load, enable, zero flag, parameterised width), instanced twice: drain counter and memory timer.
- Counter widths $clog2 of the respective parameter.

## Test plan
- Load-use: load_use_hazard=1 for one cycle in RUN → stall_if=stall_id=flush_id_ex=1 that cycle only, pc_sel=0.
- Memory wait: mem_req_ex_mem=1, mem_ack low 3 cycles then high → all stalls high 3 cycles, low on ack cycle, state RUN.
- Timeout: MEM_TIMEOUT=4, no ack → mem_timeout+flush_ex_mem in 4th wait cycle, then RUN.
- Interrupt: INT_DRAIN=2, int_req pulse → 2 drain cycles, then int_ack=1 with pc_sel=2; second int_req ignored until rti_ex gives pc_sel=3 and int_active drops.
- Priority: branch_taken+load_use_hazard together → pc_sel=1, flushes only, no stall_id; rti_ex+int_req together → pc_sel=3, no int_ack.
- Async reset asserted mid-INT_DRAIN between edges → outputs zero immediately, no int_ack after release.
